// File: rtl/ram_burst_if.sv
// ram_burst_if: splits a cache line read/write into an MSB-first burst of
// narrow RAM beats, one aval/rack handshake per beat, with a per-beat
// timeout that aborts the burst and reports err alongside ack.
module ram_burst_if #(
   parameter int LINE_W  = 64,
   parameter int RAM_W   = 8,
   parameter int ADDR_W  = 13,
   parameter int TIMEOUT = 16
) (
   input  logic              cache_clk,
   input  logic              reset_n,
   input  logic              wr,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr_c,
   input  logic [LINE_W-1:0] wdata_c,
   output logic [LINE_W-1:0] rdata_c,
   output logic              ack,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] addr_r,
   output logic [RAM_W-1:0]  wdata_r,
   output logic              rnw,
   output logic              aval,
   input  logic [RAM_W-1:0]  rdata_r,
   input  logic              rack
);
   localparam int BEATS  = LINE_W / RAM_W;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ABORT} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic [LINE_W-1:0] wline_reg, wline_next;
   logic              is_read_reg, is_read_next;
   logic [BEAT_W-1:0] beat_reg, beat_next;
   logic [WAIT_W-1:0] wait_reg, wait_next;
   logic [LINE_W-1:0] rbuf_reg;
   logic [LINE_W-1:0] line_in;
   logic              capture;
   logic [RAM_W-1:0]  wbeat [BEATS];

   logic [LINE_W-1:0] rdata_c_next;
   logic [ADDR_W-1:0] addr_r_next;
   logic [RAM_W-1:0]  wdata_r_next;
   logic              ack_next, err_next, busy_next, rnw_next, aval_next;

   // Per-beat slicing: beat k maps to line bits counted down from the MSB.
   // line_in is the read buffer with the current beat's rdata_r merged in,
   // so the final beat reaches rdata_c on the same edge that raises ack.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
         assign wbeat[gi] = wline_next[LINE_W-1-gi*RAM_W -: RAM_W];
         assign line_in[LINE_W-1-gi*RAM_W -: RAM_W] =
            (capture && beat_reg == BEAT_W'(gi)) ? rdata_r
                                                  : rbuf_reg[LINE_W-1-gi*RAM_W -: RAM_W];
      end
   endgenerate

   // State register
   always_ff @(posedge cache_clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic: rack only matters in WAIT
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (wr || rd) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT: begin
            if (rack)                   state_next = (beat_reg == LAST_BEAT) ? DONE : ISSUE;
            else if (wait_reg == WAIT_LAST) state_next = ABORT;
         end
         DONE:    state_next = IDLE;
         ABORT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request latch, beat/wait counters and read-capture enable
   always_comb begin
      base_next    = base_reg;
      wline_next   = wline_reg;
      is_read_next = is_read_reg;
      beat_next    = beat_reg;
      wait_next    = wait_reg;
      capture      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (wr) begin
               base_next    = addr_c;
               wline_next   = wdata_c;
               is_read_next = 1'b0;
               beat_next    = '0;
            end else if (rd) begin
               base_next    = addr_c;
               wline_next   = wdata_c;
               is_read_next = 1'b1;
               beat_next    = '0;
            end
         end
         ISSUE: wait_next = '0;
         WAIT: begin
            if (rack) begin
               capture = is_read_reg;
               if (beat_reg != LAST_BEAT) beat_next = beat_reg + 1'b1;
            end else begin
               wait_next = wait_reg + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Output values for the next cycle, derived from the state being entered
   always_comb begin
      aval_next    = (state_next == ISSUE);
      ack_next     = (state_next == DONE) || (state_next == ABORT);
      err_next     = (state_next == ABORT);
      busy_next    = (state_next != IDLE);
      addr_r_next  = addr_r;
      wdata_r_next = wdata_r;
      rnw_next     = rnw;
      rdata_c_next = rdata_c;
      if (state_next == ISSUE) begin
         addr_r_next  = base_next + ADDR_W'(beat_next);
         wdata_r_next = wbeat[beat_next];
         rnw_next     = is_read_next;
      end
      if (state_next == DONE && is_read_reg) rdata_c_next = line_in;
   end

   // Datapath and output registers
   always_ff @(posedge cache_clk or negedge reset_n) begin
      if (!reset_n) begin
         base_reg    <= '0;
         wline_reg   <= '0;
         is_read_reg <= 1'b0;
         beat_reg    <= '0;
         wait_reg    <= '0;
         rbuf_reg    <= '0;
         rdata_c     <= '0;
         addr_r      <= '0;
         wdata_r     <= '0;
         rnw         <= 1'b0;
         aval        <= 1'b0;
         ack         <= 1'b0;
         err         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         base_reg    <= base_next;
         wline_reg   <= wline_next;
         is_read_reg <= is_read_next;
         beat_reg    <= beat_next;
         wait_reg    <= wait_next;
         rbuf_reg    <= line_in;
         rdata_c     <= rdata_c_next;
         addr_r      <= addr_r_next;
         wdata_r     <= wdata_r_next;
         rnw         <= rnw_next;
         aval        <= aval_next;
         ack         <= ack_next;
         err         <= err_next;
         busy        <= busy_next;
      end
   end
endmodule

// File: tb/tb_ram_burst_if.sv
// Testbench for ram_burst_if: acts as the RAM (rack after a per-beat delay,
// 0 = never), predicts beat addresses/data, ack cycle, err and rdata_c from
// the burst rules, and checks everything through check_val.
module tb_ram_burst_if;
   localparam int LINE_W  = 64;
   localparam int RAM_W   = 8;
   localparam int ADDR_W  = 13;
   localparam int TIMEOUT = 16;
   localparam int BEATS   = LINE_W / RAM_W;

   logic              cache_clk = 1'b0;
   logic              reset_n   = 1'b0;
   logic              wr = 1'b0, rd = 1'b0, rack = 1'b0;
   logic [ADDR_W-1:0] addr_c = '0;
   logic [LINE_W-1:0] wdata_c = '0;
   logic [RAM_W-1:0]  rdata_r = '0;
   logic [LINE_W-1:0] rdata_c;
   logic [ADDR_W-1:0] addr_r;
   logic [RAM_W-1:0]  wdata_r;
   logic              ack, err, busy, rnw, aval;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                n_txn    = 0;
   int                dly [BEATS];
   logic [RAM_W-1:0]  rbyte [BEATS];
   logic [LINE_W-1:0] model_rdata = '0;

   ram_burst_if #(.LINE_W(LINE_W), .RAM_W(RAM_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .cache_clk(cache_clk), .reset_n(reset_n), .wr(wr), .rd(rd),
      .addr_c(addr_c), .wdata_c(wdata_c), .rdata_c(rdata_c), .ack(ack), .err(err),
      .busy(busy), .addr_r(addr_r), .wdata_r(wdata_r), .rnw(rnw), .aval(aval),
      .rdata_r(rdata_r), .rack(rack)
   );

   always #5 cache_clk = ~cache_clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One burst. Starts and ends just after a falling edge.
   task automatic run_burst(input string name, input bit do_wr, input bit do_rd,
                            input logic [ADDR_W-1:0] base, input logic [LINE_W-1:0] line,
                            input bit poke, input int rst_beat);
      bit                is_rd, exp_err, done;
      int                exp_ack, exp_naval, naval, cur, due, ack_cyc;
      logic [LINE_W-1:0] exp_line, exp_rdata, shifted;
      logic [ADDR_W-1:0] exp_addr;

      is_rd     = !do_wr;
      exp_err   = 1'b0;
      exp_ack   = 1;
      exp_naval = BEATS;
      for (int k = 0; k < BEATS; k++) begin
         if (!exp_err) begin
            if (dly[k] < 1 || dly[k] > TIMEOUT) begin
               exp_err   = 1'b1;
               exp_naval = k + 1;
               exp_ack   = exp_ack + 1 + TIMEOUT;
            end else begin
               exp_ack = exp_ack + 1 + dly[k];
            end
         end
      end
      exp_line = '0;
      for (int k = 0; k < BEATS; k++) exp_line = (exp_line << RAM_W) | LINE_W'(rbyte[k]);
      exp_rdata = (is_rd && !exp_err) ? exp_line : model_rdata;

      wr = do_wr; rd = do_rd; addr_c = base; wdata_c = line;
      @(posedge cache_clk);
      naval = 0; cur = 0; due = -1; done = 1'b0; ack_cyc = -1;
      for (int cyc = 1; cyc <= exp_ack + 4 && !done; cyc++) begin
         @(negedge cache_clk);
         if (aval) begin
            if (naval >= BEATS) begin
               check_val("aval_extra", 64'(naval), 64'(BEATS - 1));
            end else begin
               exp_addr = ADDR_W'(int'(base) + naval);
               check_val("addr_r", 64'(addr_r), 64'(exp_addr));
               check_val("rnw", 64'(rnw), 64'(is_rd));
               if (!is_rd) begin
                  shifted = line >> (LINE_W - (naval + 1) * RAM_W);
                  check_val("wdata_r", 64'(wdata_r), 64'(shifted[RAM_W-1:0]));
               end
               cur = naval;
               due = (dly[cur] >= 1) ? cyc + dly[cur] : -1;
               if (rst_beat == cur) begin
                  #2 reset_n = 1'b0;
                  #1;
                  check_val("rst_aval", 64'(aval), 64'd0);
                  check_val("rst_busy", 64'(busy), 64'd0);
                  check_val("rst_ack", 64'(ack), 64'd0);
                  check_val("rst_addr_r", 64'(addr_r), 64'd0);
                  check_val("rst_rdata_c", rdata_c, 64'd0);
                  model_rdata = '0;
                  done = 1'b1;
               end
            end
            naval++;
         end
         if (!done) begin
            check_val("busy", 64'(busy), 64'd1);
            if (ack) begin
               done    = 1'b1;
               ack_cyc = cyc;
               check_val("ack_cycle", 64'(cyc), 64'(exp_ack));
               check_val("err", 64'(err), 64'(exp_err));
               check_val("aval_count", 64'(naval), 64'(exp_naval));
               check_val("rdata_c", rdata_c, exp_rdata);
               model_rdata = exp_rdata;
            end else begin
               check_val("err_early", 64'(err), 64'd0);
            end
         end
         rack = 1'b0; rdata_r = RAM_W'($urandom);
         wr = 1'b0; rd = 1'b0;
         addr_c = ADDR_W'($urandom); wdata_c = {$urandom, $urandom};
         if (!done) begin
            if (due == cyc) begin
               rack    = 1'b1;
               rdata_r = rbyte[cur];
            end else if (aval && $urandom_range(0, 1) == 1) begin
               rack = 1'b1;   // lands in ISSUE, must be ignored
            end
            if (poke) begin
               wr = 1'($urandom_range(0, 1));
               rd = 1'($urandom_range(0, 1));
            end
         end
      end
      if (!done) check_val("ack_seen", 64'd0, 64'd1);
      if (rst_beat < 0) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge cache_clk);
            check_val("post_ack", 64'(ack), 64'd0);
            check_val("post_busy", 64'(busy), 64'd0);
            check_val("post_aval", 64'(aval), 64'd0);
         end
      end
      n_txn++;
      $display("txn %0d %s: %s base=%h line=%h ack_cyc=%0d exp_ack=%0d err=%0b rdata_c=%h",
               n_txn, name, is_rd ? "RD" : "WR", base, line, ack_cyc, exp_ack, err, rdata_c);
   endtask

   task automatic set_delays(input int lo, input int hi);
      for (int k = 0; k < BEATS; k++) begin
         dly[k]   = $urandom_range(hi, lo);
         rbyte[k] = RAM_W'($urandom);
      end
   endtask

   initial begin
      for (int k = 0; k < BEATS; k++) begin dly[k] = 1; rbyte[k] = '0; end
      repeat (3) @(negedge cache_clk);
      check_val("reset_rdata_c", rdata_c, 64'd0);
      check_val("reset_ack", 64'(ack), 64'd0);
      check_val("reset_err", 64'(err), 64'd0);
      check_val("reset_busy", 64'(busy), 64'd0);
      check_val("reset_addr_r", 64'(addr_r), 64'd0);
      check_val("reset_wdata_r", 64'(wdata_r), 64'd0);
      check_val("reset_rnw", 64'(rnw), 64'd0);
      check_val("reset_aval", 64'(aval), 64'd0);
      reset_n = 1'b1;
      @(negedge cache_clk);

      set_delays(1, 1);
      run_burst("write_zero_wait", 1'b1, 1'b0, 13'h0100, 64'h0123456789ABCDEF, 1'b0, -1);

      for (int k = 0; k < BEATS; k++) begin dly[k] = 3; rbyte[k] = RAM_W'(8'hA0 + k); end
      run_burst("read_rack3", 1'b0, 1'b1, 13'h0040, 64'h0, 1'b0, -1);

      set_delays(1, 1);
      run_burst("read_wrap", 1'b0, 1'b1, 13'h1FFC, 64'h0, 1'b0, -1);

      set_delays(1, 1);
      dly[2] = 0;
      run_burst("read_timeout_b2", 1'b0, 1'b1, 13'h0200, 64'h0, 1'b0, -1);

      set_delays(1, 3);
      run_burst("wr_rd_both_poke", 1'b1, 1'b1, 13'h0A55, {$urandom, $urandom}, 1'b1, -1);

      set_delays(TIMEOUT, TIMEOUT);
      run_burst("read_rack_last_wait", 1'b0, 1'b1, 13'h0777, 64'h0, 1'b0, -1);

      set_delays(1, 2);
      dly[0] = TIMEOUT + 1;
      run_burst("write_timeout_b0", 1'b1, 1'b0, 13'h0123, {$urandom, $urandom}, 1'b0, -1);

      for (int t = 0; t < 16; t++) begin
         bit rw, rr;
         rw = 1'($urandom_range(0, 1));
         rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
         set_delays(1, 4);
         if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, BEATS - 1)] = 0;
         run_burst("random", rw, rr, ADDR_W'($urandom), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), -1);
      end

      set_delays(1, 2);
      run_burst("write_reset_b4", 1'b1, 1'b0, 13'h0300, {$urandom, $urandom}, 1'b0, 4);
      rack = 1'b0; wr = 1'b0; rd = 1'b0;
      repeat (2) @(negedge cache_clk);
      check_val("held_reset_ack", 64'(ack), 64'd0);
      reset_n = 1'b1;
      @(negedge cache_clk);
      check_val("after_reset_busy", 64'(busy), 64'd0);
      set_delays(1, 3);
      run_burst("read_after_reset", 1'b0, 1'b1, 13'h1FFE, 64'h0, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
